// File: rtl/ld_ext_unit.sv
// Load-data extraction/extension unit: selects the addressed byte/half/word/dword lane
// from a memory read word, sign- or zero-extends it, flags misalignment, and queues results.
module ld_ext_unit #(
    parameter  int DW    = 32,
    parameter  int TW    = 5,
    parameter  int DEPTH = 2,
    localparam int OFFW  = $clog2(DW / 8)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [OFFW-1:0] in_addr_lo,
    input  logic [1:0]      in_size,
    input  logic            in_ext,
    input  logic [TW-1:0]   in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [TW-1:0]   out_tag,
    output logic            out_misalign,
    output logic [15:0]     err_cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Stage A registers
    logic            r_valid_a;
    logic [DW-1:0]   r_data_a;
    logic [OFFW-1:0] r_off_a;
    logic [1:0]      r_size_a;
    logic            r_ext_a;
    logic [TW-1:0]   r_tag_a;

    // Output FIFO
    logic [DW-1:0] r_mem_data [DEPTH];
    logic [TW-1:0] r_mem_tag  [DEPTH];
    logic          r_mem_mis  [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_err_cnt;

    logic                 w_pop;
    logic                 w_room;
    logic                 w_push;
    logic                 w_accept;
    logic [PW-1:0]        w_wptr_next;
    logic [PW-1:0]        w_rptr_next;
    logic [1:0]           w_size_eff;
    logic [6:0]           w_sh;
    logic [DW-1:0]        w_shifted;
    logic [DW-1:0]        w_up;
    logic signed [DW-1:0] w_up_s;
    logic [DW-1:0]        w_ext_val;
    logic                 w_misalign;
    logic [DW-1:0]        w_result;

    // Lane is moved to the top of the word, then shifted back down arithmetically
    // or logically so one path covers every size and both extension modes.
    always_comb begin
        w_size_eff = ((DW == 32) && (r_size_a == 2'b11)) ? 2'b10 : r_size_a;
        w_shifted  = r_data_a >> {r_off_a, 3'b000};
        case (w_size_eff)
            2'b00:   w_sh = 7'(DW - 8);
            2'b01:   w_sh = 7'(DW - 16);
            2'b10:   w_sh = 7'(DW - 32);
            default: w_sh = 7'd0;
        endcase
        w_up      = w_shifted << w_sh;
        w_up_s    = w_up;
        w_ext_val = r_ext_a ? $unsigned(w_up_s >>> w_sh) : (w_up >> w_sh);
        case (w_size_eff)
            2'b01:   w_misalign = r_off_a[0];
            2'b10:   w_misalign = |r_off_a[1:0];
            2'b11:   w_misalign = |r_off_a;
            default: w_misalign = 1'b0;
        endcase
        w_result = w_misalign ? '0 : w_ext_val;
    end

    assign w_pop       = (r_count != '0) && out_ready;
    assign w_room      = (r_count < CW'(DEPTH)) || w_pop;
    assign w_push      = r_valid_a && w_room;
    assign in_ready    = !r_valid_a || w_room;
    assign w_accept    = in_valid && in_ready;
    assign w_wptr_next = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
    assign w_rptr_next = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_a <= 1'b0;
            r_data_a  <= '0;
            r_off_a   <= '0;
            r_size_a  <= '0;
            r_ext_a   <= 1'b0;
            r_tag_a   <= '0;
        end else if (w_accept) begin
            r_valid_a <= 1'b1;
            r_data_a  <= in_data;
            r_off_a   <= in_addr_lo;
            r_size_a  <= in_size;
            r_ext_a   <= in_ext;
            r_tag_a   <= in_tag;
        end else if (w_push) begin
            r_valid_a <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_tag[i]  <= '0;
                r_mem_mis[i]  <= 1'b0;
            end
        end else if (w_push) begin
            r_mem_data[r_wptr] <= w_result;
            r_mem_tag[r_wptr]  <= r_tag_a;
            r_mem_mis[r_wptr]  <= w_misalign;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_next;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_misalign && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign out_valid    = (r_count != '0);
    assign out_data     = r_mem_data[r_rptr];
    assign out_tag      = r_mem_tag[r_rptr];
    assign out_misalign = r_mem_mis[r_rptr];
    assign err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_ld_ext_unit.sv
// Bench for ld_ext_unit: a queue-based reference model checks a DW=32 instance every cycle;
// directed cases pin literal results, backpressure, async reset, saturation and DW=64 lanes.
module tb_ld_ext_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  in_addr_lo = '0;
    logic [1:0]  in_size = '0;
    logic        in_ext = 1'b0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_misalign;
    logic [15:0] err_cnt;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [63:0] b_in_data = '0;
    logic [2:0]  b_in_addr_lo = '0;
    logic [1:0]  b_in_size = '0;
    logic        b_in_ext = 1'b0;
    logic [4:0]  b_in_tag = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [63:0] b_out_data;
    logic [4:0]  b_out_tag;
    logic        b_out_misalign;
    logic [15:0] b_err_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ld_ext_unit #(.DW(32), .TW(5), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_addr_lo(in_addr_lo), .in_size(in_size), .in_ext(in_ext), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_misalign(out_misalign), .err_cnt(err_cnt)
    );

    ld_ext_unit #(.DW(64), .TW(5), .DEPTH(2)) u_dut64 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_addr_lo(b_in_addr_lo), .in_size(b_in_size), .in_ext(b_in_ext), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_tag(b_out_tag), .out_misalign(b_out_misalign), .err_cnt(b_err_cnt)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Reference: gather nb bytes starting at byte off, then fill the upper bits.
    function automatic void ref_ext(input int dw, input logic [63:0] d, input int off,
                                    input int size, input logic ext,
                                    output logic [63:0] r, output logic m);
        int nb;
        logic [63:0] lane;
        nb = (size == 0) ? 1 : (size == 1) ? 2 : (size == 2) ? 4 : ((dw == 64) ? 8 : 4);
        m = (off % nb) != 0;
        lane = '0;
        for (int i = 0; i < nb; i++)
            if (off + i < dw / 8) lane[8*i +: 8] = d[8*(off+i) +: 8];
        if (ext && lane[8*nb-1])
            for (int b = 8 * nb; b < 64; b++) lane[b] = 1'b1;
        if (dw == 32) lane[63:32] = '0;
        r = m ? 64'd0 : lane;
    endfunction

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        mis;
        int          acc;
    } item_t;

    item_t      mq[$];
    logic [4:0] dut_tags[$];
    int         edge_n = 0;
    int         mis_acc = 0;

    // Model state reflects all edges so far; it predicts the next edge after checking.
    always @(negedge clk) begin : model
        logic        exp_ov;
        logic        exp_ir;
        logic        a_mis;
        int          pushed;
        item_t       it;
        logic [63:0] r;
        logic        m;
        if (rst) begin
            mq.delete();
            edge_n  = 0;
            mis_acc = 0;
        end else begin
            exp_ov = (mq.size() > 0) && (mq[0].acc < edge_n);
            exp_ir = (mq.size() <= DEPTH) || out_ready;
            check("out_valid", 64'(out_valid), 64'(exp_ov));
            check("in_ready", 64'(in_ready), 64'(exp_ir));
            if (exp_ov && out_valid) begin
                check("out_data", 64'(out_data), 64'(mq[0].data));
                check("out_tag", 64'(out_tag), 64'(mq[0].tag));
                check("out_misalign", 64'(out_misalign), 64'(mq[0].mis));
            end
            a_mis = (mq.size() > 0) &&
                    ((mq[mq.size()-1].acc == edge_n) || (mq.size() == DEPTH + 1)) &&
                    mq[mq.size()-1].mis;
            pushed = mis_acc - (a_mis ? 1 : 0);
            check("err_cnt", 64'(err_cnt), 64'((pushed > 65535) ? 65535 : pushed));
            if (out_valid && out_ready) dut_tags.push_back(out_tag);
            if (exp_ov && out_ready) void'(mq.pop_front());
            if (in_valid && exp_ir) begin
                ref_ext(32, 64'(in_data), int'(in_addr_lo), int'(in_size), in_ext, r, m);
                it.data = r[31:0];
                it.tag  = in_tag;
                it.mis  = m;
                it.acc  = edge_n + 1;
                mq.push_back(it);
                if (m) mis_acc++;
            end
            edge_n++;
        end
    end

    // Called just after a rising edge with the unit idle and out_ready=1.
    task automatic send_one(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                            input logic ex, input logic [4:0] tg,
                            output logic [31:0] od, output logic [4:0] ot, output logic om);
        in_valid = 1'b1; in_data = d; in_addr_lo = off; in_size = sz; in_ext = ex; in_tag = tg;
        @(negedge clk);
        check("ready_before_accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("latency_out_valid", 64'(out_valid), 64'd1);
        od = out_data; ot = out_tag; om = out_misalign;
        @(posedge clk); #1;
    endtask

    task automatic send64(input logic [63:0] d, input logic [2:0] off, input logic [1:0] sz,
                          input logic ex, output logic [63:0] od, output logic om);
        b_in_valid = 1'b1; b_in_data = d; b_in_addr_lo = off; b_in_size = sz; b_in_ext = ex;
        b_in_tag = 5'd17;
        @(negedge clk);
        check("b_ready_before_accept", 64'(b_in_ready), 64'd1);
        @(posedge clk); #1 b_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b_latency_out_valid", 64'(b_out_valid), 64'd1);
        check("b_out_tag", 64'(b_out_tag), 64'd17);
        od = b_out_data; om = b_out_misalign;
        @(posedge clk); #1;
    endtask

    task automatic drain(input string nm);
        int k;
        in_valid = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (!out_valid && mq.size() == 0) break;
            k++;
        end
        check(nm, 64'(mq.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] od;
        logic [4:0]  ot;
        logic        om;
        logic [63:0] bd;
        logic        bm;
        logic [63:0] rr;
        logic        rm;
        int          acc;
        int          nt;
        int          guard;

        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_misalign", 64'(out_misalign), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1 rst = 1'b0;

        send_one(32'h80FF7F01, 2'd3, 2'd0, 1'b1, 5'd1, od, ot, om);
        check("t1_byte3_sext", 64'(od), 64'hFFFFFF80);
        check("t1_tag", 64'(ot), 64'd1);
        send_one(32'h80FF7F01, 2'd0, 2'd0, 1'b0, 5'd2, od, ot, om);
        check("t1_byte0_zext", 64'(od), 64'h00000001);

        send_one(32'h80FF7F01, 2'd2, 2'd1, 1'b1, 5'd3, od, ot, om);
        check("t2_half2_sext", 64'(od), 64'hFFFF80FF);
        send_one(32'h80FF7F01, 2'd2, 2'd1, 1'b0, 5'd4, od, ot, om);
        check("t2_half2_zext", 64'(od), 64'h000080FF);
        send_one(32'h80FF7F01, 2'd0, 2'd2, 1'b1, 5'd5, od, ot, om);
        check("t2_word0", 64'(od), 64'h80FF7F01);
        check("t2_word0_mis", 64'(om), 64'd0);

        send_one(32'h80FF7F01, 2'd1, 2'd1, 1'b1, 5'd7, od, ot, om);
        check("t3_half1_data", 64'(od), 64'd0);
        check("t3_half1_mis", 64'(om), 64'd1);
        check("t3_half1_tag", 64'(ot), 64'd7);
        send_one(32'h80FF7F01, 2'd2, 2'd2, 1'b0, 5'd9, od, ot, om);
        check("t3_word2_data", 64'(od), 64'd0);
        check("t3_word2_mis", 64'(om), 64'd1);
        check("t3_word2_tag", 64'(ot), 64'd9);
        check("t3_err_cnt", 64'(err_cnt), 64'd2);

        send64(64'h8000_0000_0000_0001, 3'd0, 2'd3, 1'b1, bd, bm);
        check("t6_dword0", bd, 64'h8000_0000_0000_0001);
        check("t6_dword0_mis", 64'(bm), 64'd0);
        send64(64'h8000_0000_0000_0001, 3'd4, 2'd2, 1'b1, bd, bm);
        check("t6_word4_sext", bd, 64'hFFFF_FFFF_8000_0000);
        send64(64'h8000_0000_0000_0001, 3'd4, 2'd3, 1'b0, bd, bm);
        check("t6_dword4_data", bd, 64'd0);
        check("t6_dword4_mis", 64'(bm), 64'd1);
        check("t6_err_cnt", 64'(b_err_cnt), 64'd1);
        for (int k = 0; k < 8; k++) begin
            logic [63:0] rd;
            logic [2:0]  ro;
            logic [1:0]  rs;
            logic        re;
            rd = {$urandom, $urandom};
            ro = 3'($urandom_range(0, 7));
            rs = 2'($urandom_range(0, 3));
            re = 1'($urandom_range(0, 1));
            send64(rd, ro, rs, re, bd, bm);
            ref_ext(64, rd, int'(ro), int'(rs), re, rr, rm);
            check("t6_rand_data", bd, rr);
            check("t6_rand_mis", 64'(bm), 64'(rm));
        end

        // Backpressure: only FIFO + stage A can be filled while out_ready is low.
        out_ready = 1'b0;
        nt = 1;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_tag = 5'(nt); in_data = $urandom;
            in_addr_lo = 2'd0; in_size = 2'd2; in_ext = 1'b0;
            @(negedge clk);
            if (in_ready) begin acc++; nt++; end
            @(posedge clk); #1;
        end
        check("t4_accepted_under_stall", 64'(acc), 64'd3);
        @(negedge clk);
        check("t4_ready_low_when_full", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        dut_tags.delete();
        out_ready = 1'b1;
        guard = 0;
        while (nt <= 5 && guard < 50) begin
            in_valid = 1'b1; in_tag = 5'(nt); in_data = $urandom;
            @(negedge clk);
            if (in_ready) nt++;
            @(posedge clk); #1;
            guard++;
        end
        check("t4_all_accepted", 64'(nt), 64'd6);
        drain("t4_drain");
        check("t4_exit_count", 64'(dut_tags.size()), 64'd5);
        for (int i = 0; i < dut_tags.size(); i++)
            check("t4_exit_order", 64'(dut_tags[i]), 64'(i + 1));

        // Async reset with two entries queued and stage A occupied.
        send_one(32'h0000_0100, 2'd1, 2'd2, 1'b0, 5'd11, od, ot, om);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = $urandom; in_addr_lo = 2'd0; in_size = 2'd2;
            in_ext = 1'b0; in_tag = 5'(20 + k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t5_async_out_valid", 64'(out_valid), 64'd0);
        check("t5_async_err_cnt", 64'(err_cnt), 64'd0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_in_ready_after_rst", 64'(in_ready), 64'd1);
        check("t5_out_valid_after_rst", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        send_one(32'h1234_5678, 2'd2, 2'd1, 1'b0, 5'd30, od, ot, om);
        check("t5_post_rst_data", 64'(od), 64'h0000_1234);
        check("t5_post_rst_tag", 64'(ot), 64'd30);

        for (int c = 0; c < 3000; c++) begin
            in_valid   = ($urandom_range(0, 9) < 6);
            in_data    = $urandom;
            in_addr_lo = 2'($urandom_range(0, 3));
            in_size    = 2'($urandom_range(0, 3));
            in_ext     = 1'($urandom_range(0, 1));
            in_tag     = 5'($urandom_range(0, 31));
            out_ready  = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        drain("rand_drain");

        // err_cnt saturation
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_addr_lo = 2'd1; in_size = 2'd1; in_ext = 1'b0;
        acc = 0;
        guard = 0;
        while (acc < 65534 && guard < 70000) begin
            in_tag = 5'(acc);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        check("sat_accepts", 64'(acc), 64'd65534);
        drain("sat_drain");
        check("sat_err_fffe", 64'(err_cnt), 64'hFFFE);
        send_one(32'hDEAD_BEEF, 2'd3, 2'd2, 1'b1, 5'd1, od, ot, om);
        check("sat_err_ffff", 64'(err_cnt), 64'hFFFF);
        send_one(32'hDEAD_BEEF, 2'd1, 2'd1, 1'b1, 5'd2, od, ot, om);
        check("sat_err_hold", 64'(err_cnt), 64'hFFFF);
        check("sat_mis", 64'(om), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
